// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 feed-forward convolutional encoder with a serial
// c0-then-c1 output stream and a valid/ready input handshake.
// Compile-time option: CONV_TAIL_EN appends K-1 zero tail bits per frame
// (terminated code). When it is undefined, the shift register carries
// across frames and no tail cycles are inserted.
module conv_encoder #(
    parameter int unsigned    FRAME_LEN = 6,
    parameter int unsigned    K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101
) (
    input  logic clk,
    input  logic rst,
    input  logic data_i,
    input  logic valid_i,
    output logic ready_o,
    output logic data_o,
    output logic valid_o,
    output logic frame_start_o
);

    localparam int unsigned BIT_W  = $clog2(FRAME_LEN + 1);
`ifdef CONV_TAIL_EN
    localparam int unsigned TAIL_W = $clog2(K);

    typedef enum logic [0:0] {S_DATA = 1'b0, S_TAIL = 1'b1} state_t;
`else
    typedef enum logic [0:0] {S_DATA = 1'b0} state_t;
`endif

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [K-2:0]       sr_q, sr_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
`ifdef CONV_TAIL_EN
    logic [TAIL_W-1:0]  tail_cnt_q, tail_cnt_d;
`endif
    logic               c1_hold_q, c1_hold_d;
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic               frame_start_q, frame_start_d;

    logic               accept;
    logic               advance;
    logic               enc_bit;
    logic [K-1:0]       u;
    logic               c0;
    logic               c1;

    assign ready_o       = (state_q == S_DATA) && !phase_q && !rst;
    assign accept        = valid_i && ready_o;
    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign frame_start_o = frame_start_q;

    // Encoder datapath: pick the bit to encode and form both parity outputs
    always_comb begin
        enc_bit = 1'b0;
        advance = accept;
        if (state_q == S_DATA) begin
            enc_bit = data_i;
        end
`ifdef CONV_TAIL_EN
        // Tail bits are zeros and need no handshake
        if (state_q == S_TAIL && !phase_q) begin
            advance = 1'b1;
        end
`endif
        u  = {enc_bit, sr_q};
        c0 = ^(u & G0);
        c1 = ^(u & G1);
    end

    // State register and all output/datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_DATA;
            phase_q       <= 1'b0;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
`ifdef CONV_TAIL_EN
            tail_cnt_q    <= '0;
`endif
            c1_hold_q     <= 1'b0;
            data_q        <= 1'b0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
`ifdef CONV_TAIL_EN
            tail_cnt_q    <= tail_cnt_d;
`endif
            c1_hold_q     <= c1_hold_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next-state: phase toggling, shift register, frame and tail counters
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
`ifdef CONV_TAIL_EN
        tail_cnt_d = tail_cnt_q;
`endif
        if (!phase_q) begin
            if (advance) begin
                phase_d = 1'b1;
                // u[K-1:1] is {new bit, sr[K-2:1]}: shift in at the MSB
                sr_d    = u[K-1:1];
                if (state_q == S_DATA) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end else begin
            phase_d = 1'b0;
            case (state_q)
                S_DATA: begin
                    if (bit_cnt_q == BIT_W'(FRAME_LEN)) begin
                        bit_cnt_d = '0;
`ifdef CONV_TAIL_EN
                        state_d   = S_TAIL;
`endif
                    end
                end
`ifdef CONV_TAIL_EN
                S_TAIL: begin
                    if (tail_cnt_q == TAIL_W'(K - 2)) begin
                        tail_cnt_d = '0;
                        state_d    = S_DATA;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Output: c0 on the encode cycle, held c1 on the following cycle
    always_comb begin
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        c1_hold_d     = c1_hold_q;
        if (!phase_q) begin
            if (advance) begin
                data_d        = c0;
                valid_d       = 1'b1;
                c1_hold_d     = c1;
                frame_start_d = (state_q == S_DATA) && (bit_cnt_q == '0);
            end
        end else begin
            data_d  = c1_hold_q;
            valid_d = 1'b1;
        end
    end

endmodule
